// File: rtl/if_id_queue.sv
// Fetch-to-decode instruction queue: small FIFO of {pc, instr} pairs with
// backpressure to fetch, redirect flush, and a saturating flush statistic.
module if_id_queue #(
   parameter int DEPTH = 4,
   parameter int AW    = 2,
   parameter int CNTW  = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            f_valid,
   input  logic [31:0]     f_pc,
   input  logic [31:0]     f_instr,
   output logic            f_ready,
   output logic            d_valid,
   output logic [31:0]     d_pc,
   output logic [31:0]     d_pc_plus1,
   output logic [31:0]     d_instr,
   input  logic            d_ready,
   input  logic            flush,
   output logic [AW:0]     count,
   output logic [CNTW-1:0] flush_cnt
);

   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [63:0]     mem [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [AW:0]     count_r;
   logic [CNTW-1:0] flush_cnt_r;
   logic            empty;
   logic            full;
   logic            push;
   logic            pop;

   function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   assign empty   = (count_r == '0);
   assign full    = (count_r == FULL_CNT);
   assign f_ready = ~full & ~flush;
   assign d_valid = ~empty & ~flush;
   assign push    = f_valid & f_ready;
   assign pop     = d_valid & d_ready;

   // Control state; flush wins over any handshake and drops the whole queue.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count_r     <= '0;
         flush_cnt_r <= '0;
      end else if (flush) begin
         count_r <= '0;
         rd_ptr  <= wr_ptr;
         if (!empty) flush_cnt_r <= sat_inc(flush_cnt_r);
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)      count_r <= count_r + 1'b1;
         else if (pop && !push) count_r <= count_r - 1'b1;
      end
   end

   // Storage is not reset; empty-queue outputs are forced below instead.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= {f_pc, f_instr};
   end

   always_comb begin
      d_pc    = '0;
      d_instr = '0;
      if (!empty) begin
         d_pc    = mem[rd_ptr][63:32];
         d_instr = mem[rd_ptr][31:0];
      end
   end

   assign d_pc_plus1 = d_pc + 32'd1;
   assign count      = count_r;
   assign flush_cnt  = flush_cnt_r;

endmodule
